clk_divider_bank: RTL and testbench

- Parametrised, multi-channel successor to the fixed 1 Hz divider.
- Generates NUM_CH independent square-wave clocks from clk_50MHz. Each channel has a runtime-programmable half-period, a per-channel enable, a complementary output and a single-cycle tick strobe.
- Divisor updates are shadowed and take effect only at a half-period boundary, so outputs never glitch. A global phase-align input restarts all channels together.
- Sits between the board clock and the display, debounce and LED-blink logic.

---
 rtl/clk_divider_bank.sv | 149 ++++++++++++++
 tb/tb_clk_divider_bank.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_bank.sv
// Bank of NUM_CH independent square-wave generators derived from clk_50MHz.
// Each channel has a shadowed half-period register, an enable, a complementary output and a rise tick.
module clk_divider_bank #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = 26,
  parameter int unsigned DEFAULT_HALF = 24_999_999
) (
  input  logic              clk_50MHz,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              wr_en,
  input  logic [3:0]        wr_ch,
  input  logic [CNT_W-1:0]  wr_half,
  input  logic              phase_sync,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] not_clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    state_t           st, st_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] act_half, act_half_nxt;
    logic [CNT_W-1:0] pend_half, pend_half_nxt;
    logic             pend_valid, pend_valid_nxt;
    logic             clk_q, clk_nxt;
    logic             tick_q, tick_nxt;
    logic             wr_hit;
    logic             term;

    // Out-of-range channel indices match no channel and are dropped.
    assign wr_hit = wr_en && (wr_ch == 4'(i));
    assign term   = (cnt == act_half);

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
        st <= IDLE;
      end else begin
        st <= st_nxt;
      end
    end

    always_comb begin
      st_nxt = st;
      case (st)
        IDLE:    if (ch_en[i])  st_nxt = RUN;
        RUN:     if (!ch_en[i]) st_nxt = IDLE;
        default: st_nxt = IDLE;
      endcase
    end

    // Next-value logic; phase_sync outranks terminal count, enable handling is unaffected.
    always_comb begin
      cnt_nxt        = cnt;
      clk_nxt        = clk_q;
      tick_nxt       = 1'b0;
      act_half_nxt   = act_half;
      pend_half_nxt  = pend_half;
      pend_valid_nxt = pend_valid;

      if (wr_hit) begin
        pend_half_nxt  = wr_half;
        pend_valid_nxt = 1'b1;
      end

      if (phase_sync) begin
        cnt_nxt = '0;
        clk_nxt = 1'b0;
        if (wr_hit) begin
          act_half_nxt   = wr_half;
          pend_valid_nxt = 1'b0;
        end else if (pend_valid) begin
          act_half_nxt   = pend_half;
          pend_valid_nxt = 1'b0;
        end
      end else begin
        case (st_nxt)
          IDLE: begin
            cnt_nxt = '0;
            clk_nxt = 1'b0;
            if (pend_valid) begin
              act_half_nxt   = pend_half;
              pend_valid_nxt = wr_hit;
            end
          end
          RUN: begin
            if (term) begin
              cnt_nxt  = '0;
              clk_nxt  = ~clk_q;
              tick_nxt = ~clk_q;
              // A write landing on the boundary skips the shadow register.
              if (wr_hit) begin
                act_half_nxt   = wr_half;
                pend_valid_nxt = 1'b0;
              end else if (pend_valid) begin
                act_half_nxt   = pend_half;
                pend_valid_nxt = 1'b0;
              end
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
          default: begin
            cnt_nxt = '0;
            clk_nxt = 1'b0;
          end
        endcase
      end
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
        cnt        <= '0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
        act_half   <= HALF_RST;
        pend_half  <= HALF_RST;
        pend_valid <= 1'b0;
      end else begin
        cnt        <= cnt_nxt;
        clk_q      <= clk_nxt;
        tick_q     <= tick_nxt;
        act_half   <= act_half_nxt;
        pend_half  <= pend_half_nxt;
        pend_valid <= pend_valid_nxt;
      end
    end

    // Complement kept in its own flop so both outputs come straight from registers.
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
        not_clk_out[i] <= 1'b1;
      end else begin
        not_clk_out[i] <= ~clk_nxt;
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
  end

endmodule

// File: tb/tb_clk_divider_bank.sv
// Directed bench for clk_divider_bank: vector table plus hand-written corner sequences.
// DEFAULT_HALF is scaled down to 9 so the reset-default behaviour fits a short run.
module tb_clk_divider_bank;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned CNT_W  = 26;
  localparam int unsigned DEF_H  = 9;

  logic              clk_50MHz = 1'b0;
  logic              rst_n     = 1'b0;
  logic [NUM_CH-1:0] ch_en     = '0;
  logic              wr_en     = 1'b0;
  logic [3:0]        wr_ch     = '0;
  logic [CNT_W-1:0]  wr_half   = '0;
  logic              phase_sync = 1'b0;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] not_clk_out;
  logic [NUM_CH-1:0] tick;

  int n_tests = 0;
  int n_fail  = 0;

  clk_divider_bank #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_HALF(DEF_H)
  ) dut (
    .clk_50MHz  (clk_50MHz),
    .rst_n      (rst_n),
    .ch_en      (ch_en),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_half    (wr_half),
    .phase_sync (phase_sync),
    .clk_out    (clk_out),
    .not_clk_out(not_clk_out),
    .tick       (tick)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  typedef struct {
    logic [1:0]       en;
    logic             wr;
    logic [3:0]       ch;
    logic [CNT_W-1:0] half;
    logic [1:0]       exp_clk;
    logic [1:0]       exp_tick;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [1:0] en, input logic wr, input logic [3:0] ch,
                              input int unsigned half, input logic [1:0] c, input logic [1:0] t);
    vec_t v;
    v.en = en; v.wr = wr; v.ch = ch; v.half = CNT_W'(half);
    v.exp_clk = c; v.exp_tick = t;
    return v;
  endfunction

  task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [1:0] c, input logic [1:0] t);
    check({name, " clk_out"}, clk_out, c);
    check({name, " not_clk_out"}, not_clk_out, ~c);
    check({name, " tick"}, tick, t);
  endtask

  task automatic step();
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic drive(input logic w, input logic [3:0] ch, input int unsigned half, input logic s);
    wr_en = w; wr_ch = ch; wr_half = CNT_W'(half); phase_sync = s;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ch_en = '0;
    drive(1'b0, 4'd0, 0, 1'b0);
    #7;
    @(negedge clk_50MHz);
    rst_n = 1'b1;
  endtask

  // Expected output of a channel running at the default half-period, n edges after enable.
  task automatic check_default_run(input string name, input int cycles);
    for (int n = 1; n <= cycles; n++) begin
      step();
      check_outs($sformatf("%s e%0d", name, n),
                 ((n / 10) % 2 == 1) ? 2'b11 : 2'b00,
                 (n % 20 == 10) ? 2'b11 : 2'b00);
    end
  endtask

  initial begin
    // Table: ch1 programmed to half=3 in IDLE, bad-index write ignored, then half=0.
    vq.push_back(mk(2'b00, 1, 4'd1, 3, 2'b00, 2'b00));
    vq.push_back(mk(2'b00, 0, 4'd0, 0, 2'b00, 2'b00));
    vq.push_back(mk(2'b10, 0, 4'd0, 0, 2'b00, 2'b00));
    vq.push_back(mk(2'b10, 0, 4'd0, 0, 2'b00, 2'b00));
    vq.push_back(mk(2'b10, 0, 4'd0, 0, 2'b00, 2'b00));
    vq.push_back(mk(2'b10, 0, 4'd0, 0, 2'b10, 2'b10));
    vq.push_back(mk(2'b10, 0, 4'd0, 0, 2'b10, 2'b00));
    vq.push_back(mk(2'b10, 0, 4'd0, 0, 2'b10, 2'b00));
    vq.push_back(mk(2'b10, 0, 4'd0, 0, 2'b10, 2'b00));
    vq.push_back(mk(2'b10, 0, 4'd0, 0, 2'b00, 2'b00));
    vq.push_back(mk(2'b10, 0, 4'd0, 0, 2'b00, 2'b00));
    vq.push_back(mk(2'b10, 0, 4'd0, 0, 2'b00, 2'b00));
    vq.push_back(mk(2'b10, 0, 4'd0, 0, 2'b00, 2'b00));
    vq.push_back(mk(2'b10, 0, 4'd0, 0, 2'b10, 2'b10));
    vq.push_back(mk(2'b10, 1, 4'd7, 0, 2'b10, 2'b00));
    vq.push_back(mk(2'b10, 0, 4'd0, 0, 2'b10, 2'b00));
    vq.push_back(mk(2'b10, 0, 4'd0, 0, 2'b10, 2'b00));
    vq.push_back(mk(2'b10, 0, 4'd0, 0, 2'b00, 2'b00));
    vq.push_back(mk(2'b10, 1, 4'd1, 0, 2'b00, 2'b00));
    vq.push_back(mk(2'b10, 0, 4'd0, 0, 2'b00, 2'b00));
    vq.push_back(mk(2'b10, 0, 4'd0, 0, 2'b00, 2'b00));
    vq.push_back(mk(2'b10, 0, 4'd0, 0, 2'b10, 2'b10));
    vq.push_back(mk(2'b10, 0, 4'd0, 0, 2'b00, 2'b00));
    vq.push_back(mk(2'b10, 0, 4'd0, 0, 2'b10, 2'b10));
    vq.push_back(mk(2'b10, 0, 4'd0, 0, 2'b00, 2'b00));
    vq.push_back(mk(2'b10, 0, 4'd0, 0, 2'b10, 2'b10));

    // Reset defaults, then both channels free-running at DEFAULT_HALF.
    #12;
    check_outs("reset", 2'b00, 2'b00);
    @(negedge clk_50MHz);
    rst_n = 1'b1;
    ch_en = 2'b11;
    check_default_run("default", 35);

    // Mid-period write to ch0, then async reset must discard it.
    drive(1'b1, 4'd0, 2, 1'b0);
    step();
    drive(1'b0, 4'd0, 0, 1'b0);
    check_outs("pre-reset e36", 2'b11, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async reset", 2'b00, 2'b00);
    ch_en = 2'b00;
    @(negedge clk_50MHz);
    rst_n = 1'b1;
    ch_en = 2'b11;
    check_default_run("after reset", 25);

    do_reset();
    foreach (vq[k]) begin
      ch_en = vq[k].en;
      drive(vq[k].wr, vq[k].ch, int'(vq[k].half), 1'b0);
      step();
      check_outs($sformatf("vec%0d", k), vq[k].exp_clk, vq[k].exp_tick);
    end

    // Glitch-free update: half=4, rewrites at cnt=2 (last wins), then a write on a terminal edge.
    begin
      bit g_clk [16] = '{0,0,0,0,1,1,0,0,1,1,0,0,1,0,1,0};
      bit g_tk  [16] = '{0,0,0,0,1,0,0,0,1,0,0,0,1,0,1,0};
      do_reset();
      drive(1'b1, 4'd0, 4, 1'b0);
      step();
      drive(1'b0, 4'd0, 0, 1'b0);
      step();
      ch_en = 2'b01;
      for (int e = 1; e <= 16; e++) begin
        if (e == 3)       drive(1'b1, 4'd0, 7, 1'b0);
        else if (e == 4)  drive(1'b1, 4'd0, 1, 1'b0);
        else if (e == 13) drive(1'b1, 4'd0, 0, 1'b0);
        else              drive(1'b0, 4'd0, 0, 1'b0);
        step();
        check_outs($sformatf("glitch e%0d", e), {1'b0, g_clk[e-1]}, {1'b0, g_tk[e-1]});
      end
      drive(1'b0, 4'd0, 0, 1'b0);
    end

    // phase_sync with coincident ch0 terminal, then ch0 enable drop and re-enable.
    begin
      bit s0c [13] = '{0,0,1,1,1,0,0,0,1,0,0,0,1};
      bit s0t [13] = '{0,0,1,0,0,0,0,0,1,0,0,0,1};
      bit s1c [13] = '{0,0,0,0,0,1,1,1,1,1,1,0,0};
      bit s1t [13] = '{0,0,0,0,0,1,0,0,0,0,0,0,0};
      do_reset();
      drive(1'b1, 4'd0, 2, 1'b0);
      step();
      drive(1'b1, 4'd1, 5, 1'b0);
      step();
      drive(1'b0, 4'd0, 0, 1'b0);
      step();
      ch_en = 2'b11;
      for (int e = 1; e <= 8; e++) step();
      check_outs("pre-sync", 2'b10, 2'b00);
      drive(1'b0, 4'd0, 0, 1'b1);
      step();
      drive(1'b0, 4'd0, 0, 1'b0);
      check_outs("sync edge", 2'b00, 2'b00);
      for (int s = 1; s <= 13; s++) begin
        ch_en = (s == 10) ? 2'b10 : 2'b11;
        step();
        check_outs($sformatf("sync s%0d", s), {s1c[s-1], s0c[s-1]}, {s1t[s-1], s0t[s-1]});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
